// File: rtl/sad_pkg.sv
// Shared definitions for the SAD search controller and the SAD engine it drives.
package sad_pkg;

  localparam int SAD_W_DEF = 32;

  // One-hot so busy/sad_go/done decode straight from single flops.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_WAIT  = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  localparam int ST_IDLE_BIT  = 0;
  localparam int ST_ISSUE_BIT = 1;
  localparam int ST_DONE_BIT  = 3;

  // Engine handshake: go is a one-cycle request for the presented candidate;
  // the engine answers with a one-cycle done (sad_val valid alongside) at least
  // ENG_MIN_LAT cycles later. Exactly one done per go.
  localparam int ENG_MIN_LAT = 1;

endpackage

// File: rtl/sad_cand_gen.sv
// Raster-order candidate counter over the -RANGE..+RANGE window (x fastest).
module sad_cand_gen #(
  parameter int RANGE = 7,
  parameter int MV_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   step,
  output logic signed [MV_W-1:0] cand_x,
  output logic signed [MV_W-1:0] cand_y,
  output logic                   last
);

  localparam logic signed [MV_W-1:0] POS = MV_W'(RANGE);
  localparam logic signed [MV_W-1:0] NEG = -POS;
  localparam logic signed [MV_W-1:0] ONE = MV_W'(1);

  assign last = (cand_x == POS) && (cand_y == POS);

  // Stepping past the final candidate holds it, so y never leaves the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_x <= '0;
      cand_y <= '0;
    end else if (clear) begin
      cand_x <= NEG;
      cand_y <= NEG;
    end else if (step && !last) begin
      if (cand_x == POS) begin
        cand_x <= NEG;
        cand_y <= cand_y + ONE;
      end else begin
        cand_x <= cand_x + ONE;
      end
    end
  end

endmodule

// File: rtl/sad_search_ctrl.sv
// Full-search motion-estimation sequencer: walks every candidate, drives the SAD
// engine go/done handshake and keeps the minimum SAD with its motion vector.
module sad_search_ctrl
  import sad_pkg::*;
#(
  parameter int RANGE = 7,
  parameter int SAD_W = SAD_W_DEF,
  parameter int MV_W  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic                   result_valid,
  output logic                   sad_go,
  output logic signed [MV_W-1:0] cand_x,
  output logic signed [MV_W-1:0] cand_y,
  input  logic                   sad_done,
  input  logic [SAD_W-1:0]       sad_val,
  output logic [SAD_W-1:0]       best_sad,
  output logic signed [MV_W-1:0] best_x,
  output logic signed [MV_W-1:0] best_y
);

  state_t state, state_nxt;
  logic   cand_clear, cand_step, cand_last, aborting;

  assign cand_clear = (state == ST_IDLE) && start;
  assign aborting   = (state != ST_IDLE) && abort;
  assign cand_step  = (state == ST_WAIT) && sad_done && !abort;

  sad_cand_gen #(.RANGE(RANGE), .MV_W(MV_W)) u_cand (
    .clk    (clk),
    .rst    (rst),
    .clear  (cand_clear),
    .step   (cand_step),
    .cand_x (cand_x),
    .cand_y (cand_y),
    .last   (cand_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (sad_done) state_nxt = cand_last ? ST_DONE : ST_ISSUE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (aborting) state_nxt = ST_IDLE;
  end

  always_comb begin
    busy   = !state[ST_IDLE_BIT];
    sad_go = state[ST_ISSUE_BIT];
    done   = state[ST_DONE_BIT];
  end

  // Strict less-than keeps the earliest candidate on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_sad     <= '0;
      best_x       <= '0;
      best_y       <= '0;
      result_valid <= 1'b0;
    end else begin
      if (cand_clear) begin
        best_sad     <= '1;
        best_x       <= '0;
        best_y       <= '0;
        result_valid <= 1'b0;
      end
      if (cand_step) begin
        if (sad_val < best_sad) begin
          best_sad <= sad_val;
          best_x   <= cand_x;
          best_y   <= cand_y;
        end
        if (cand_last) result_valid <= 1'b1;
      end
      if (aborting) result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sad_search_ctrl.sv
// Bench for sad_search_ctrl: stub SAD engine with programmable latency and a
// table-driven reference of the full-search minimum.
module tb_sad_search_ctrl;

  localparam int R    = 1;
  localparam int W    = 2 * R + 1;
  localparam int N    = W * W;
  localparam int MV_W = 5;

  logic clk, rst, start, abort, busy, done, result_valid, sad_go, sad_done;
  logic signed [MV_W-1:0] cand_x, cand_y, best_x, best_y;
  logic [31:0] sad_val, best_sad;

  sad_search_ctrl #(.RANGE(R), .SAD_W(32), .MV_W(MV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .result_valid(result_valid), .sad_go(sad_go), .cand_x(cand_x), .cand_y(cand_y),
    .sad_done(sad_done), .sad_val(sad_val), .best_sad(best_sad),
    .best_x(best_x), .best_y(best_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, lat = 3, pend = 0, eidx = 0, n_go = 0;
  bit noise = 0, fired = 0;
  logic [31:0] tbl [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: scan candidates in raster order, keep strictly smaller SAD.
  task automatic model(output logic [31:0] bs, output int bx, output int by);
    bs = 32'hFFFF_FFFF; bx = 0; by = 0;
    for (int i = 0; i < N; i++)
      if (tbl[i] < bs) begin
        bs = tbl[i]; bx = i % W - R; by = i / W - R;
      end
  endtask

  // Advance one cycle, then play the engine for the new cycle.
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    sad_done = 1'b0;
    fired    = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        sad_done = 1'b1; sad_val = tbl[eidx]; fired = 1'b1;
      end
    end
    if (sad_go) begin
      if (n_go < N) begin
        check("cand_x", cand_x, n_go % W - R);
        check("cand_y", cand_y, n_go / W - R);
      end else begin
        check("extra_go", n_go, N - 1);
      end
      eidx = n_go; n_go++; pend = lat;
      if (noise) begin
        sad_done = 1'b1; sad_val = 32'd0;
      end
    end
  endtask

  task automatic run(input int abort_idx, input int rst_idx);
    int s, exp_done, bx, by;
    logic [31:0] bs;
    bit seen;
    n_go = 0; pend = 0; seen = 0;
    start = 1'b1; s = cyc;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("rv_cleared", result_valid, 0);
    exp_done = s + 1 + N * (1 + lat);
    for (int t = 0; t < 400 && !seen; t++) begin
      if (done) begin
        seen = 1'b1;
      end else if (fired && eidx == abort_idx) begin
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_rv", result_valid, 0);
        check("abort_gos", n_go, abort_idx + 1);
        tick();
        check("abort_no_done", done, 0);
        return;
      end else if (pend > 0 && !fired && eidx == rst_idx) begin
        #2 rst = 1'b1;
        #1;
        check("arst_ctrl", {busy, done, result_valid, sad_go}, 0);
        check("arst_cand", {cand_x, cand_y}, 0);
        check("arst_best", {best_sad, best_x, best_y}, 0);
        pend = 0; sad_done = 1'b0;
        tick(); tick();
        #1 rst = 1'b0;
        return;
      end else begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
    end
    start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
      return;
    end
    model(bs, bx, by);
    check("done_cycle", cyc, exp_done);
    check("go_count", n_go, N);
    check("rv_with_done", result_valid, 1);
    check("best_sad", best_sad, bs);
    check("best_x", best_x, bx);
    check("best_y", best_y, by);
    tick();
    check("done_pulse", {busy, done}, 0);
    check("rv_hold", result_valid, 1);
    check("best_sad_hold", best_sad, bs);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; sad_done = 1'b0; sad_val = '0;
    #3;
    check("reset_ctrl", {busy, done, result_valid, sad_go}, 0);
    check("reset_cand", {cand_x, cand_y}, 0);
    check("reset_best", {best_sad, best_x, best_y}, 0);
    tick(); tick();
    #1 rst = 1'b0;
    tick();

    // Descending SADs: last candidate wins.
    lat = 3;
    for (int i = 0; i < N; i++) tbl[i] = 100 - 10 * i;
    run(-1, -1);
    // All equal: first candidate wins.
    lat = 2;
    for (int i = 0; i < N; i++) tbl[i] = 50;
    run(-1, -1);
    // Single minimum at the centre.
    lat = 1;
    for (int i = 0; i < N; i++) tbl[i] = (i == 4) ? 7 : 200;
    run(-1, -1);
    // Abort coincident with the 4th sad_done, then a full search.
    lat = 3;
    for (int i = 0; i < N; i++) tbl[i] = 100 - 10 * i;
    run(3, -1);
    for (int i = 0; i < N; i++) tbl[i] = $urandom_range(0, 300);
    run(-1, -1);
    // Start while busy and spurious sad_done in ISSUE must be ignored.
    noise = 1'b1;
    for (int i = 0; i < N; i++) tbl[i] = 100 - 10 * i;
    run(-1, -1);
    noise = 1'b0;
    // Asynchronous reset mid-WAIT, then a normal search.
    run(-1, 5);
    check("post_rst_idle", busy, 0);
    run(-1, -1);
    // Randomized back-to-back searches.
    for (int k = 0; k < 12; k++) begin
      lat = $urandom_range(1, 4);
      noise = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        tbl[i] = (k % 2 == 0) ? 32'($urandom_range(0, 7)) : $urandom;
      run(-1, -1);
    end
    noise = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Full-search motion-estimation sequencer that drives the SAD engine over every candidate position in a ±RANGE search window. It issues one SAD computation per candidate in raster order and waits for each result. It tracks the minimum SAD and its motion vector, then reports the winner with a one-cycle done pulse. It sits between the frame-level control and the SAD engine, and owns the engine's go/done handshake.

## Interface
Parameters:
- RANGE, 7, search range in pixels per axis; candidates are -RANGE..+RANGE in x and y, giving (2·RANGE+1)² positions.
- SAD_W, 32, SAD value width; must match the engine's accumulator.
- MV_W, 5, signed two's-complement width of the motion-vector components; must satisfy 2^(MV_W-1)-1 ≥ RANGE.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request to begin a search; sampled only in IDLE.
- abort  in  1  cancels an in-progress search; highest priority after rst.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a search completes.
- result_valid  out  1  high from done until the next accepted start, abort or rst.
- sad_go  out  1  one-cycle pulse to the engine: compute the SAD for cand_x/cand_y.
- cand_x, cand_y  out  MV_W each  signed current candidate offsets; stable from sad_go until the matching sad_done.
- sad_done  in  1  one-cycle pulse from the engine; sad_val is valid in the same cycle.
- sad_val  in  SAD_W  SAD result from the engine.
- best_sad  out  SAD_W  minimum SAD found.
- best_x, best_y  out  MV_W each  signed offsets of the minimum.

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - start=1 → ISSUE.
  - On that edge: cand_x=cand_y=-RANGE, best_sad=all ones, best_x=best_y=0, result_valid=0.
- ISSUE: sad_go=1 for exactly this cycle → WAIT.
- WAIT: hold until sad_done=1. On that edge:
  - If sad_val < best_sad (unsigned, strictly less), load best_sad=sad_val, best_x=cand_x, best_y=cand_y. Ties keep the earlier candidate.
  - Advance in raster order: x increments first. At x=+RANGE, x wraps to -RANGE and y increments.
  - If the finished candidate was (+RANGE,+RANGE) → DONE; otherwise → ISSUE.
- DONE: done=1 for this cycle only. result_valid is set on the edge entering DONE → IDLE.
- abort in any non-IDLE state:
  - → IDLE on the next edge; done is not asserted and result_valid stays 0.
  - best_* hold their partial values and are meaningless.
  - An abort in the same cycle as sad_done wins; no update occurs.
- start while busy is ignored. sad_done outside WAIT is ignored.
- rst:
  - State → IDLE.
  - All outputs are 0, including best_sad=0, cand_x=cand_y=0 and result_valid=0.
  - A reset in mid-search drops the search silently.
- Candidate comparison is unsigned on SAD_W bits. Candidate arithmetic is signed on MV_W bits and never overflows, given the parameter constraint.

## Timing
- start → sad_go: 1 cycle (IDLE edge, then the ISSUE cycle).
- Per candidate: 1 ISSUE cycle plus engine latency L (L ≥ 1 cycle from sad_go to sad_done).
- Total search time, start to done: (2·RANGE+1)²·(1+L) + 1 cycles.
- Back-to-back operation: a start in the cycle after done is accepted.
- Outputs are registered except sad_go, busy and done, which are decoded from the state register (glitch-free, one-hot state encoding).
- best_* are stable and valid whenever result_valid=1.

## Structure
- Shared package sad_pkg holds:
  - the SAD_W default and the state encoding constants (IDLE/ISSUE/WAIT/DONE);
  - the engine handshake definition (go/done pulse contract), which the SAD engine also uses.
- Sub-module sad_cand_gen: a raster x/y counter with clear (to -RANGE), step, and a last-candidate flag. The FSM and the min-tracker stay in sad_search_ctrl.

## Test plan
- RANGE=1 with a stub engine (L=3) returning SAD = 100 − 10·index for index 0..8 → exactly 9 sad_go pulses; done after 9·4+1=37 cycles; best_sad=20, best_x=+1, best_y=+1.
- RANGE=1 with all SADs equal to 50 → best_sad=50, best=(-1,-1) (first candidate wins ties).
- RANGE=1, minimum 7 at raster index 4 and all others 200 → best=(0,0), best_sad=7; result_valid rises together with done.
- abort asserted during the 4th WAIT, coincident with sad_done → no done, result_valid=0, busy drops the next cycle; a following start runs a full 9-candidate search correctly.
- Start pulsed while busy, and a spurious sad_done in ISSUE → both ignored; the candidate sequence and result match the first scenario.
- rst asserted mid-WAIT (asynchronous, between edges) → all outputs 0 immediately, state IDLE; a start after release gives the normal result.
